// File: rtl/game_pkg.sv
// game_pkg: shared types and widths for the bomb-defuse round controller.
//   state_e     - controller FSM states
//   SCREEN_W    - width of a screen value / screen position index
//   ROUND_W     - width of the round (hit) counter
//   STRIKE_W    - width of the strike counter
//   find_target - position of the first screen equal to the main screen
package game_pkg;

    localparam int unsigned SCREEN_W = 2;
    localparam int unsigned ROUND_W  = 3;
    localparam int unsigned STRIKE_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_GEN,
        ARMED,
        DEFUSED,
        EXPLODED
    } state_e;

    // Priority First > Second > Third > Fourth; position 0 if nothing matches.
    function automatic logic [SCREEN_W-1:0] find_target(
        input logic [SCREEN_W-1:0] first,
        input logic [SCREEN_W-1:0] second,
        input logic [SCREEN_W-1:0] third,
        input logic [SCREEN_W-1:0] fourth,
        input logic [SCREEN_W-1:0] main_scr
    );
        logic [SCREEN_W-1:0] idx;
        if (first == main_scr) begin
            idx = SCREEN_W'(0);
        end else if (second == main_scr) begin
            idx = SCREEN_W'(1);
        end else if (third == main_scr) begin
            idx = SCREEN_W'(2);
        end else if (fourth == main_scr) begin
            idx = SCREEN_W'(3);
        end else begin
            idx = SCREEN_W'(0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// game_round_ctrl_if: generator and player signals of the round controller.
//   Gen_Req        - one-cycle request to the screen generator's button input
//   Gen_Done       - generator screen-done flag (level)
//   *_Screen       - generated screen values and main-screen value
//   Player_Valid   - one-cycle player selection strobe
//   Player_Sel     - selected position, 0 = First .. 3 = Fourth
//   Input_Enable   - player input window open
// Modports: master = controller side, slave = generator/player side.
interface game_round_ctrl_if;
    import game_pkg::*;

    logic                Gen_Req;
    logic                Gen_Done;
    logic [SCREEN_W-1:0] First_Screen;
    logic [SCREEN_W-1:0] Second_Screen;
    logic [SCREEN_W-1:0] Third_Screen;
    logic [SCREEN_W-1:0] Fourth_Screen;
    logic [SCREEN_W-1:0] Main_Screen;
    logic                Player_Valid;
    logic [SCREEN_W-1:0] Player_Sel;
    logic                Input_Enable;

    modport master (
        output Gen_Req,
        output Input_Enable,
        input  Gen_Done,
        input  First_Screen,
        input  Second_Screen,
        input  Third_Screen,
        input  Fourth_Screen,
        input  Main_Screen,
        input  Player_Valid,
        input  Player_Sel
    );

    modport slave (
        input  Gen_Req,
        input  Input_Enable,
        output Gen_Done,
        output First_Screen,
        output Second_Screen,
        output Third_Screen,
        output Fourth_Screen,
        output Main_Screen,
        output Player_Valid,
        output Player_Sel
    );

endinterface

// File: rtl/round_timer.sv
// round_timer: loadable down-counter with a zero flag. Stops at zero.
//   CLK      - clock, rising edge
//   RST      - asynchronous active-low reset (count = 0)
//   load     - load load_val (wins over en)
//   load_val - value to load
//   en       - decrement while non-zero
//   zero     - count is zero
module round_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round sequencer for the bomb-defuse game.
// Requests a screen arrangement, latches the target position, opens a player
// window, judges the selection and tracks hits (Round) and Strikes.
//   CLK, RST     - clock (rising edge), asynchronous active-low reset
//   Start        - start/restart, level-sampled in IDLE/DEFUSED/EXPLODED
//   bus          - generator/player interface (master modport)
//   Round        - hits completed so far
//   Strikes      - strikes accumulated
//   Hit/Miss/Timeout - one-cycle result pulses
//   Defused/Exploded - terminal status, held until Start
// Build option: ROUND_TIMEOUT_EN adds the response-window counter and Timeout
// strikes; without it ARMED waits indefinitely and Timeout is tied low.
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int unsigned ROUNDS        = 4,
    parameter int unsigned MAX_STRIKES   = 3,
    parameter int unsigned WINDOW_CYCLES = 1000,
    parameter int unsigned GEN_TIMEOUT   = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Start,
    game_round_ctrl_if.master     bus,
    output logic [ROUND_W-1:0]    Round,
    output logic [STRIKE_W-1:0]   Strikes,
    output logic                  Hit,
    output logic                  Miss,
    output logic                  Timeout,
    output logic                  Defused,
    output logic                  Exploded
);

    localparam logic [ROUND_W-1:0]  ROUNDS_L  = ROUND_W'(ROUNDS);
    localparam logic [STRIKE_W-1:0] STRIKES_L = STRIKE_W'(MAX_STRIKES);
    localparam int unsigned WD_W = (GEN_TIMEOUT > 2) ? $clog2(GEN_TIMEOUT) : 1;

    state_e              state_q, state_d;
    logic [SCREEN_W-1:0] target_q, target_d;
    logic [ROUND_W-1:0]  round_q, round_d;
    logic [STRIKE_W-1:0] strikes_q, strikes_d;
    logic                hit_q, hit_d;
    logic                miss_q, miss_d;
    logic                gen_done_q;
    logic                gen_edge;
    logic                wd_zero;
    logic                strike;

    // Only a fresh rising edge counts; a level left high from the last round does not.
    assign gen_edge = bus.Gen_Done & ~gen_done_q;

    // Generator watchdog: loaded in REQ, runs in WAIT_GEN.
    round_timer #(
        .WIDTH(WD_W)
    ) u_wd_timer (
        .CLK     (CLK),
        .RST     (RST),
        .load    (state_q == REQ),
        .load_val(WD_W'(GEN_TIMEOUT - 1)),
        .en      (state_q == WAIT_GEN),
        .zero    (wd_zero)
    );

`ifdef ROUND_TIMEOUT_EN
    localparam int unsigned WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;

    logic win_zero;
    logic timeout_q, timeout_d;

    // Response window: loaded on the generator edge, runs while ARMED.
    round_timer #(
        .WIDTH(WIN_W)
    ) u_win_timer (
        .CLK     (CLK),
        .RST     (RST),
        .load    ((state_q == WAIT_GEN) && gen_edge),
        .load_val(WIN_W'(WINDOW_CYCLES - 1)),
        .en      (state_q == ARMED),
        .zero    (win_zero)
    );

    assign Timeout = timeout_q;
`else
    // Window length has no effect without the window counter.
    logic unused_window_cfg;
    assign unused_window_cfg = ^WINDOW_CYCLES;
    assign Timeout           = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        round_d   = round_q;
        strikes_d = strikes_q;
        hit_d     = 1'b0;
        miss_d    = 1'b0;
        strike    = 1'b0;
`ifdef ROUND_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            IDLE, DEFUSED, EXPLODED: begin
                if (Start) begin
                    round_d   = '0;
                    strikes_d = '0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                state_d = WAIT_GEN;
            end
            WAIT_GEN: begin
                if (gen_edge) begin
                    target_d = find_target(bus.First_Screen, bus.Second_Screen,
                                           bus.Third_Screen, bus.Fourth_Screen,
                                           bus.Main_Screen);
                    state_d  = ARMED;
                end else if (wd_zero) begin
                    state_d = REQ;
                end
            end
            ARMED: begin
                // Player input beats a simultaneous window expiry.
                if (bus.Player_Valid) begin
                    if (bus.Player_Sel == target_q) begin
                        hit_d = 1'b1;
                        if (round_q < ROUNDS_L) begin
                            round_d = round_q + 1'b1;
                        end
                        state_d = (round_q + 1'b1 == ROUNDS_L) ? DEFUSED : REQ;
                    end else begin
                        miss_d = 1'b1;
                        strike = 1'b1;
                    end
                end
`ifdef ROUND_TIMEOUT_EN
                else if (win_zero) begin
                    timeout_d = 1'b1;
                    strike    = 1'b1;
                end
`endif
                if (strike) begin
                    if (strikes_q < STRIKES_L) begin
                        strikes_d = strikes_q + 1'b1;
                    end
                    state_d = (strikes_q + 1'b1 == STRIKES_L) ? EXPLODED : REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            target_q   <= '0;
            round_q    <= '0;
            strikes_q  <= '0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            gen_done_q <= 1'b0;
`ifdef ROUND_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            round_q    <= round_d;
            strikes_q  <= strikes_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            gen_done_q <= bus.Gen_Done;
`ifdef ROUND_TIMEOUT_EN
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign bus.Gen_Req      = (state_q == REQ);
    assign bus.Input_Enable = (state_q == ARMED);
    assign Round            = round_q;
    assign Strikes          = strikes_q;
    assign Hit              = hit_q;
    assign Miss             = miss_q;
    assign Defused          = (state_q == DEFUSED);
    assign Exploded         = (state_q == EXPLODED);

endmodule

// File: doc/game_round_ctrl.md
# game_round_ctrl

Sequencing controller for the bomb-defuse gameplay loop. On each round it requests a fresh four-screen arrangement from the random screen generator, latches the target position (the screen whose value equals the main screen), and opens a player input window. It then judges the player's selection and advances the round counter or adds a strike. It drives the generator's button input and reports defused/exploded to the top-level display logic.

## Interface
- ROUNDS, 4: hits required to defuse (1–7)
- MAX_STRIKES, 3: strikes that detonate (1–3)
- WINDOW_CYCLES, 1000: response window per round, in clocks
- GEN_TIMEOUT, 64: clocks to wait for the generator before re-requesting
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset
- Start  in  1  start/restart the game, level-sampled
- Gen_Req  out  1  one-cycle pulse to the generator's button input
- Gen_Done  in  1  generator screen-done flag (level)
- First_Screen, Second_Screen, Third_Screen, Fourth_Screen  in  2 each  generated screen values
- Main_Screen  in  2  generated main-screen value
- Player_Valid  in  1  one-cycle player selection strobe
- Player_Sel  in  2  selected position: 0 = First … 3 = Fourth
- Input_Enable  out  1  high while the window is open
- Round  out  3  hits completed so far
- Strikes  out  2  strikes accumulated
- Hit, Miss, Timeout  out  1 each  one-cycle result pulses
- Defused, Exploded  out  1 each  terminal status, held

## Operation
- Reset: all outputs 0; state IDLE; Target register = 0; all counters = 0.
- IDLE: on Start = 1, clear Round and Strikes, then go to REQ.
- REQ: assert Gen_Req for exactly one cycle; clear the watchdog; go to WAIT_GEN.
- WAIT_GEN: wait for a rising edge of Gen_Done, detected against a registered copy of Gen_Done. A level high left over from the previous round is ignored.
  - On the edge: Target := index of the screen equal to Main_Screen, with priority First > Second > Third > Fourth. Load the window counter with WINDOW_CYCLES−1. Go to ARMED.
  - If the watchdog reaches GEN_TIMEOUT−1 first: go to REQ (retry, no strike).
- ARMED: Input_Enable = 1.
  - Player_Valid with Player_Sel == Target: Hit pulse, Round+1. If Round+1 == ROUNDS, go to DEFUSED; else go to REQ.
  - Player_Valid with Player_Sel ≠ Target: Miss pulse, Strikes+1.
  - Window counter reaches 0 without Player_Valid: Timeout pulse, Strikes+1.
  - After a strike: if Strikes+1 == MAX_STRIKES, go to EXPLODED; else go to REQ (new arrangement).
- DEFUSED / EXPLODED: hold the status flag. Start = 1 clears the flags and behaves as in IDLE (goes to REQ).
- Counters saturate. Round never exceeds ROUNDS; Strikes never exceeds MAX_STRIKES.

## Timing
- Start sampled at cycle t → Gen_Req high at t+1.
- Gen_Done rises at t → Target latched and Input_Enable high at t+1.
- Player_Valid at t in ARMED → Hit/Miss, counter update and Input_Enable low at t+1.
- Player_Valid outside ARMED is ignored.
- Player_Valid in the same cycle the window expires: the player input wins, and no Timeout pulse is issued.
- Start while in REQ, WAIT_GEN or ARMED is ignored.
- At most one of Hit, Miss, Timeout is high in any cycle.
- Reset asserted mid-round returns to IDLE immediately. The generator is not notified; its next Screen_Done edge is ignored because the controller is in IDLE.

## Configuration
- ROUND_TIMEOUT_EN defined: the window counter is built; expiry produces a Timeout strike as described above.
- ROUND_TIMEOUT_EN undefined: no window counter; ARMED waits indefinitely for Player_Valid; Timeout is tied to 0.
- The WAIT_GEN watchdog is present in both builds.

## Structure
- Shared package game_pkg holds:
  - state enum: IDLE, REQ, WAIT_GEN, ARMED, DEFUSED, EXPLODED
  - SCREEN_W = 2, ROUND_W = 3, STRIKE_W = 2
- Sub-module round_timer: a loadable down-counter with a zero flag. It is instantiated for the response window (under ROUND_TIMEOUT_EN) and for the generator watchdog.

## Test plan
- Start; generator returns screens 2,0,3,1 with main 3 → Target = 2. Player_Sel = 2 → Hit at t+1, Round = 1, Gen_Req pulses next cycle.
- Same screens, Player_Sel = 0 three times (MAX_STRIKES = 3) → three Miss pulses, then Strikes = 3 and Exploded = 1 held. Start → flags cleared, Round = 0, Gen_Req.
- Four consecutive correct selections (ROUNDS = 4) → Defused = 1 after the fourth Hit, Round = 4, no further Gen_Req.
- No player input for WINDOW_CYCLES = 16 (bench override) → Timeout pulse on cycle 16 after Input_Enable rises, Strikes = 1. With ROUND_TIMEOUT_EN undefined: no Timeout after 1000 cycles.
- Gen_Done held high from the previous round and never re-rising, GEN_TIMEOUT = 8 → Gen_Req re-pulses 8 cycles after WAIT_GEN entry; no strike.
- Player_Valid in the same cycle as window expiry with a correct selection → Hit only, no Timeout. Reset asserted mid-ARMED → all outputs 0 asynchronously.
